gp9001_gfx_fetch: RTL

GP9001_GFX_FETCH -- requirements
Module: gp9001_gfx_fetch

---
 rtl/gp9001_gfx_pkg.sv | 39 +++
 rtl/gfx_rr_arbiter.sv | 35 +++
 rtl/gp9001_gfx_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp9001_gfx_pkg.sv
// gp9001_gfx_pkg
//   Shared definitions for the GP9001 graphics fetch engine:
//   - fetch_state_e : engine FSM states
//   - gfx_decode    : raw 32-bit ROM word -> eight packed 4-bit pixels
//   - address widths (24-bit byte, 22-bit 16-bit-word) and the
//     tile/bank shift amounts used to build the ROM byte address.
package gp9001_gfx_pkg;

  localparam int BYTE_AW    = 24;
  localparam int WORD_AW    = 22;
  localparam int TILE_SHIFT = 5;
  localparam int BANK_SHIFT = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // Pixel k takes one bit from each of the four ROM bit-planes, MSB first;
  // pixel k lands in nibble k, so byte i = {pixel 2i+1, pixel 2i}.
  function automatic logic [31:0] gfx_decode(input logic [31:0] dout);
    logic [7:0]  pa;
    logic [7:0]  pb;
    logic [7:0]  pc;
    logic [7:0]  pd;
    logic [31:0] res;
    pa  = dout[15:8];
    pb  = dout[7:0];
    pc  = dout[31:24];
    pd  = dout[23:16];
    res = 32'd0;
    for (int k = 0; k < 8; k++) begin
      res[4*k +: 4] = {pd[7-k], pb[7-k], pc[7-k], pa[7-k]};
    end
    return res;
  endfunction

endpackage

// File: rtl/gfx_rr_arbiter.sv
// gfx_rr_arbiter
//   Combinational round-robin arbiter.
//   Ports:
//     req [NCH] : request vector
//     ptr [NCH] : one-hot index of the last granted channel
//     gnt [NCH] : one-hot grant (all zero when nothing requests)
//   The first requester strictly after ptr wins, wrapping around to bit 0.
module gfx_rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] ptr,
  output logic [NCH-1:0] gnt
);

  localparam logic [NCH-1:0] LSB_V = NCH'(1'b1);

  logic [NCH-1:0] hi_mask_s;
  logic [NCH-1:0] req_hi_s;
  logic [NCH-1:0] pick_s;

  // Mask off requests at or below the pointer; when ptr is the top bit the
  // shift overflows to zero and the mask is empty, giving a clean wrap.
  always_comb begin
    hi_mask_s = ~((ptr << 1) - LSB_V);
    req_hi_s  = req & hi_mask_s;
    if (req_hi_s != '0) begin
      pick_s = req_hi_s;
    end else begin
      pick_s = req;
    end
    gnt = pick_s & (~pick_s + LSB_V);
  end

endmodule

// File: rtl/gp9001_gfx_fetch.sv
// gp9001_gfx_fetch
//   Shared tile-graphics fetch engine: NCH requesters share one SDRAM path
//   split into two 8 MB halves. Each grant builds a byte address from the
//   object bank, tile number and offset, reads one 32-bit ROM word and
//   returns it decoded into eight 4-bit pixels.
//   Ports:
//     CLK96, RESET96          : clock, async active-high reset
//     BANK_SLOT/DIN/WR        : object-bank register write
//     REQ_CS/TILE/OFFS/BANK   : per-channel request level and address fields
//     REQ_DATA, REQ_OK        : per-channel decoded word and completion pulse
//     SD_CS, SD_OK            : SDRAM half select / data valid
//     SD0_ADDR/DOUT, SD1_*    : word address and data per half
//   Build option: define GFX_FETCH_CACHE_EN for a one-entry decoded-word
//   cache per channel, invalidated by any bank write.
module gp9001_gfx_fetch
  import gp9001_gfx_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NSLOT  = 8,
  parameter int BANK_W = 4
) (
  input  logic                     CLK96,
  input  logic                     RESET96,
  input  logic [$clog2(NSLOT)-1:0] BANK_SLOT,
  input  logic [15:0]              BANK_DIN,
  input  logic                     BANK_WR,
  input  logic [NCH-1:0]           REQ_CS,
  input  logic [NCH*15-1:0]        REQ_TILE,
  input  logic [NCH*16-1:0]        REQ_OFFS,
  input  logic [NCH*4-1:0]         REQ_BANK,
  output logic [NCH*32-1:0]        REQ_DATA,
  output logic [NCH-1:0]           REQ_OK,
  output logic [1:0]               SD_CS,
  input  logic [1:0]               SD_OK,
  output logic [WORD_AW-1:0]       SD0_ADDR,
  output logic [WORD_AW-1:0]       SD1_ADDR,
  input  logic [31:0]              SD0_DOUT,
  input  logic [31:0]              SD1_DOUT
);

  localparam logic [NCH-1:0] PTR_RST = NCH'(1'b1) << (NCH - 1);

  logic [BANK_W-1:0]  bank_r [NSLOT];
  fetch_state_e       state_r, state_nxt_s;
  logic [NCH-1:0]     ptr_r, ptr_nxt_s, gnt_s, gnt_r, gnt_nxt_s, eligible_s;
  logic [NCH-1:0]     served_r, served_set_s, req_ok_r, req_ok_nxt_s, wr_en_s;
  logic               half_r, half_nxt_s, any_gnt_s, sd_done_s, hit_s;
  logic [1:0]         sd_cs_r, sd_cs_nxt_s;
  logic [WORD_AW-1:0] sd0_addr_r, sd1_addr_r, sd0_addr_nxt_s, sd1_addr_nxt_s;
  logic [31:0]        data_r [NCH];
  logic [31:0]        wr_data_s, hit_data_s;
  logic [14:0]        sel_tile_s;
  logic [15:0]        sel_offs_s;
  logic [3:0]         sel_bank_s;
  logic [BANK_W-1:0]  bank_val_s;
  logic [BYTE_AW-1:0] addr_s;
  logic               unused_bits_s;

  assign unused_bits_s = ^{BANK_DIN[15:BANK_W], addr_s[0]};

  assign eligible_s = REQ_CS & ~served_r;
  assign any_gnt_s  = |gnt_s;
  assign sd_done_s  = (state_r == ST_WAIT) && SD_OK[half_r];

  gfx_rr_arbiter #(.NCH(NCH)) u_arb (
    .req (eligible_s),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  // Object-bank register file
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      for (int s = 0; s < NSLOT; s++) bank_r[s] <= '0;
    end else if (BANK_WR) begin
      bank_r[BANK_SLOT] <= BANK_DIN[BANK_W-1:0];
    end
  end

  // Select the granted channel's fields and build its ROM byte address
  always_comb begin
    sel_tile_s = 15'd0;
    sel_offs_s = 16'd0;
    sel_bank_s = 4'd0;
    bank_val_s = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_tile_s = sel_tile_s | (REQ_TILE[15*i +: 15] & {15{gnt_s[i]}});
      sel_offs_s = sel_offs_s | (REQ_OFFS[16*i +: 16] & {16{gnt_s[i]}});
      sel_bank_s = sel_bank_s | (REQ_BANK[4*i +: 4]   & {4{gnt_s[i]}});
    end
    // Slot indices beyond NSLOT read as zero
    for (int s = 0; s < NSLOT; s++) begin
      bank_val_s = bank_val_s | (bank_r[s] & {BANK_W{sel_bank_s == 4'(s)}});
    end
    addr_s = ({{(BYTE_AW-BANK_W){1'b0}}, bank_val_s} << BANK_SHIFT)
           + ({9'd0, sel_tile_s} << TILE_SHIFT)
           + {8'd0, sel_offs_s};
  end

`ifdef GFX_FETCH_CACHE_EN
  logic [BYTE_AW-1:0] tag_r   [NCH];
  logic [31:0]        cdata_r [NCH];
  logic [NCH-1:0]     cvalid_r;
  logic [BYTE_AW-1:0] addr_r;

  // Cache lookup for the channel being granted
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_s[i] && cvalid_r[i] && (tag_r[i] == addr_s)) begin
        hit_s      = 1'b1;
        hit_data_s = cdata_r[i];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Cache fill on SDRAM completion; a bank write drops every entry
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      cvalid_r <= '0;
      addr_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        tag_r[i]   <= '0;
        cdata_r[i] <= 32'd0;
      end
    end else begin
      if ((state_r == ST_IDLE) && any_gnt_s) addr_r <= addr_s;
      for (int i = 0; i < NCH; i++) begin
        if (BANK_WR) begin
          cvalid_r[i] <= 1'b0;
        end else if (sd_done_s && gnt_r[i]) begin
          cvalid_r[i] <= 1'b1;
          tag_r[i]    <= addr_r;
          cdata_r[i]  <= wr_data_s;
        end
      end
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  // FSM state register
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_gnt_s) state_nxt_s = hit_s ? ST_DONE : ST_WAIT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (sd_done_s) state_nxt_s = ST_DONE;
        else           state_nxt_s = ST_WAIT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of all registered outputs
  always_comb begin
    gnt_nxt_s      = gnt_r;
    ptr_nxt_s      = ptr_r;
    half_nxt_s     = half_r;
    sd_cs_nxt_s    = sd_cs_r;
    sd0_addr_nxt_s = sd0_addr_r;
    sd1_addr_nxt_s = sd1_addr_r;
    req_ok_nxt_s   = '0;
    wr_en_s        = '0;
    wr_data_s      = 32'd0;
    served_set_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (any_gnt_s) begin
          gnt_nxt_s  = gnt_s;
          ptr_nxt_s  = gnt_s;
          half_nxt_s = addr_s[BYTE_AW-1];
          if (hit_s) begin
            req_ok_nxt_s = gnt_s;
            wr_en_s      = gnt_s;
            wr_data_s    = hit_data_s;
            served_set_s = gnt_s;
            sd_cs_nxt_s  = 2'b00;
          end else if (addr_s[BYTE_AW-1]) begin
            sd_cs_nxt_s    = 2'b10;
            sd1_addr_nxt_s = addr_s[BYTE_AW-2:1];
          end else begin
            sd_cs_nxt_s    = 2'b01;
            sd0_addr_nxt_s = addr_s[BYTE_AW-2:1];
          end
        end else begin
          sd_cs_nxt_s = 2'b00;
        end
      end
      ST_WAIT: begin
        // The access always completes; a dropped REQ_CS only hides REQ_OK
        if (sd_done_s) begin
          sd_cs_nxt_s  = 2'b00;
          wr_en_s      = gnt_r;
          wr_data_s    = gfx_decode(half_r ? SD1_DOUT : SD0_DOUT);
          req_ok_nxt_s = gnt_r & REQ_CS;
          served_set_s = gnt_r;
        end else begin
          sd_cs_nxt_s = sd_cs_r;
        end
      end
      ST_DONE: sd_cs_nxt_s = 2'b00;
      default: sd_cs_nxt_s = 2'b00;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      ptr_r      <= PTR_RST;
      gnt_r      <= '0;
      half_r     <= 1'b0;
      sd_cs_r    <= 2'b00;
      sd0_addr_r <= '0;
      sd1_addr_r <= '0;
      req_ok_r   <= '0;
      served_r   <= '0;
      for (int i = 0; i < NCH; i++) data_r[i] <= 32'd0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      gnt_r      <= gnt_nxt_s;
      half_r     <= half_nxt_s;
      sd_cs_r    <= sd_cs_nxt_s;
      sd0_addr_r <= sd0_addr_nxt_s;
      sd1_addr_r <= sd1_addr_nxt_s;
      req_ok_r   <= req_ok_nxt_s;
      // served sticks until REQ_CS drops, giving one REQ_OK per assertion
      served_r   <= REQ_CS & (served_r | served_set_s);
      for (int i = 0; i < NCH; i++) begin
        if (wr_en_s[i]) data_r[i] <= wr_data_s;
      end
    end
  end

  assign SD_CS    = sd_cs_r;
  assign SD0_ADDR = sd0_addr_r;
  assign SD1_ADDR = sd1_addr_r;
  assign REQ_OK   = req_ok_r;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_data
    assign REQ_DATA[32*gi +: 32] = data_r[gi];
  end

endmodule
